// File: rtl/char_buf_arbiter.sv
// rtl/char_buf_arbiter.sv - line-granular round-robin arbiter feeding the VGA character buffer
//
// Shares the single character-buffer input between p_num_reqs text sources.
// A source owns the output for a whole line, which ends on LF, ESC or a stall
// timeout. An optional "<digit>:" prefix tags each granted line.
//
// Ports:
//   clk        clock
//   rst        synchronous, active-high reset
//   req_ascii  character from requester i at bits [8i+7:8i]
//   req_val    requester i has a valid character
//   req_rdy    requester i's character is accepted this cycle
//   ascii      registered character to the character buffer
//   ascii_val  ascii is valid this cycle (single-cycle pulse per character)
//   grant_idx  current or last granted requester
//   busy       a line is currently owned

module char_buf_arbiter #(
  parameter int p_num_reqs  = 4,
  parameter int p_prefix_en = 1,
  parameter int p_timeout   = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [8*p_num_reqs-1:0]       req_ascii,
  input  logic [p_num_reqs-1:0]         req_val,
  output logic [p_num_reqs-1:0]         req_rdy,
  output logic [7:0]                    ascii,
  output logic                          ascii_val,
  output logic [$clog2(p_num_reqs)-1:0] grant_idx,
  output logic                          busy
);

  localparam int lw = $clog2(p_num_reqs);
  // A zero timeout still needs a one-bit counter so the logic stays legal.
  localparam int cw = (p_timeout > 0) ? $clog2(p_timeout + 1) : 1;
  localparam logic [cw-1:0] cnt_max  = {cw{1'b1}};
  localparam logic [cw-1:0] cnt_lim  = cw'(p_timeout);
  localparam logic [lw-1:0] last_rst = lw'(p_num_reqs - 1);

  localparam logic [2:0] st_idle   = 3'd0;
  localparam logic [2:0] st_pfx0   = 3'd1;
  localparam logic [2:0] st_pfx1   = 3'd2;
  localparam logic [2:0] st_stream = 3'd3;
  localparam logic [2:0] st_flush  = 3'd4;

  localparam logic [7:0] ch_lf    = 8'h0A;
  localparam logic [7:0] ch_esc   = 8'h1B;
  localparam logic [7:0] ch_colon = 8'h3A;
  localparam logic [7:0] ch_zero  = 8'h30;

  logic [2:0]    state;
  logic [lw-1:0] last_grant;
  logic [cw-1:0] cnt;
  logic [7:0]    ascii_q;
  logic          ascii_val_q;

  logic [lw-1:0] sel_idx;
  logic          sel_found;
  logic [lw-1:0] cand;
  int            j;
  logic [7:0]    cur_char;
  logic          xfer;
  logic [cw-1:0] cnt_inc;

  // Round-robin search starting just after the last line owner.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    j         = 0;
    for (int k = 1; k <= p_num_reqs; k++) begin
      j = int'(last_grant) + k;
      if (j >= p_num_reqs) j = j - p_num_reqs;
      cand = lw'(j);
      if (!sel_found && req_val[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_comb begin
    req_rdy = '0;
    if (state == st_stream) req_rdy[grant_idx] = 1'b1;
  end

  assign cur_char = req_ascii[{grant_idx, 3'b000} +: 8];
  assign xfer     = (state == st_stream) && req_val[grant_idx];
  // Saturating increment so a disabled timeout never wraps back to zero.
  assign cnt_inc  = (cnt == cnt_max) ? cnt : cnt + cw'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= st_idle;
      grant_idx   <= '0;
      last_grant  <= last_rst;
      cnt         <= '0;
      ascii_q     <= 8'h00;
      ascii_val_q <= 1'b0;
    end else begin
      ascii_val_q <= 1'b0;
      case (state)
        st_idle: begin
          cnt <= '0;
          if (sel_found) begin
            grant_idx <= sel_idx;
            state     <= (p_prefix_en != 0) ? st_pfx0 : st_stream;
          end
        end
        st_pfx0: begin
          ascii_q     <= ch_zero + 8'(grant_idx);
          ascii_val_q <= 1'b1;
          state       <= st_pfx1;
        end
        st_pfx1: begin
          ascii_q     <= ch_colon;
          ascii_val_q <= 1'b1;
          state       <= st_stream;
        end
        st_stream: begin
          if (xfer) begin
            ascii_q     <= cur_char;
            ascii_val_q <= 1'b1;
            cnt         <= '0;
            // DEL is deliberately not a line terminator.
            if (cur_char == ch_lf || cur_char == ch_esc) begin
              last_grant <= grant_idx;
              state      <= st_idle;
            end
          end else begin
            cnt <= cnt_inc;
            if (p_timeout != 0 && cnt_inc == cnt_lim) state <= st_flush;
          end
        end
        st_flush: begin
          ascii_q     <= ch_lf;
          ascii_val_q <= 1'b1;
          last_grant  <= grant_idx;
          cnt         <= '0;
          state       <= st_idle;
        end
        default: state <= st_idle;
      endcase
    end
  end

  assign ascii     = ascii_q;
  assign ascii_val = ascii_val_q;
  assign busy      = (state != st_idle);

endmodule

// File: tb/tb_char_buf_arbiter.sv
// tb/tb_char_buf_arbiter.sv - self-checking bench for char_buf_arbiter
module tb_char_buf_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Instance a: prefix enabled, short timeout
  logic [31:0] a_req_ascii;
  logic [3:0]  a_req_val;
  logic [3:0]  a_req_rdy;
  logic [7:0]  a_ascii;
  logic        a_ascii_val;
  logic [1:0]  a_grant;
  logic        a_busy;

  // Instance b: no prefix
  logic [31:0] b_req_ascii;
  logic [3:0]  b_req_val;
  logic [3:0]  b_req_rdy;
  logic [7:0]  b_ascii;
  logic        b_ascii_val;
  logic [1:0]  b_grant;
  logic        b_busy;

  char_buf_arbiter #(.p_num_reqs(4), .p_prefix_en(1), .p_timeout(4)) dut_a (
    .clk(clk), .rst(rst),
    .req_ascii(a_req_ascii), .req_val(a_req_val), .req_rdy(a_req_rdy),
    .ascii(a_ascii), .ascii_val(a_ascii_val), .grant_idx(a_grant), .busy(a_busy)
  );

  char_buf_arbiter #(.p_num_reqs(4), .p_prefix_en(0), .p_timeout(64)) dut_b (
    .clk(clk), .rst(rst),
    .req_ascii(b_req_ascii), .req_val(b_req_val), .req_rdy(b_req_rdy),
    .ascii(b_ascii), .ascii_val(b_ascii_val), .grant_idx(b_grant), .busy(b_busy)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];
  int last_seen[256];

  task automatic push_a(input string s);
    for (int i = 0; i < s.len(); i++) exp_a.push_back(s[i]);
  endtask

  task automatic push_b(input string s);
    for (int i = 0; i < s.len(); i++) exp_b.push_back(s[i]);
  endtask

  task automatic monitor_loop();
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (a_ascii_val === 1'b1) begin
        vectors++;
        last_seen[a_ascii] = cyc;
        if (exp_a.size() == 0) begin
          $display("FAIL out_a unexpected char: got %h, required none", a_ascii);
          miscompares++;
        end else begin
          e = exp_a.pop_front();
          if (a_ascii !== e) begin
            $display("FAIL out_a char: got %h, required %h", a_ascii, e);
            miscompares++;
          end
        end
      end
      if (b_ascii_val === 1'b1) begin
        vectors++;
        if (exp_b.size() == 0) begin
          $display("FAIL out_b unexpected char: got %h, required none", b_ascii);
          miscompares++;
        end else begin
          e = exp_b.pop_front();
          if (b_ascii !== e) begin
            $display("FAIL out_b char: got %h, required %h", b_ascii, e);
            miscompares++;
          end
        end
      end
    end
  endtask

  // Presents one line on requester idx; call just after a rising edge.
  task automatic drive_line(input bit use_b, input int idx, input string s);
    int pos;
    int n;
    logic take;
    pos = 0;
    n = 0;
    if (use_b) begin
      b_req_ascii[idx*8 +: 8] = s[0];
      b_req_val[idx] = 1'b1;
    end else begin
      a_req_ascii[idx*8 +: 8] = s[0];
      a_req_val[idx] = 1'b1;
    end
    while (pos < s.len() && n < 60) begin
      @(negedge clk);
      take = use_b ? (b_req_rdy[idx] & b_req_val[idx]) : (a_req_rdy[idx] & a_req_val[idx]);
      @(posedge clk);
      #1;
      n++;
      if (take) begin
        pos++;
        if (pos < s.len()) begin
          if (use_b) b_req_ascii[idx*8 +: 8] = s[pos];
          else       a_req_ascii[idx*8 +: 8] = s[pos];
        end else begin
          if (use_b) b_req_val[idx] = 1'b0;
          else       a_req_val[idx] = 1'b0;
        end
      end
    end
    vectors++;
    if (pos < s.len()) begin
      $display("FAIL drive_line req%0d: sent %0d chars, required %0d within budget", idx, pos, s.len());
      miscompares++;
      if (use_b) b_req_val[idx] = 1'b0;
      else       a_req_val[idx] = 1'b0;
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_a.size() != 0 || exp_b.size() != 0) && n < 50) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (exp_a.size() != 0 || exp_b.size() != 0) begin
      $display("FAIL %s drain: got %0d/%0d chars outstanding, required 0/0", name, exp_a.size(), exp_b.size());
      miscompares++;
      exp_a.delete();
      exp_b.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_req_ascii = '0; a_req_val = '0;
    b_req_ascii = '0; b_req_val = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    vectors += 10;
    if (a_ascii !== 8'h00)   begin $display("FAIL reset a_ascii: got %h, required 00", a_ascii); miscompares++; end
    if (a_ascii_val !== 1'b0) begin $display("FAIL reset a_ascii_val: got %b, required 0", a_ascii_val); miscompares++; end
    if (a_req_rdy !== 4'h0)  begin $display("FAIL reset a_req_rdy: got %h, required 0", a_req_rdy); miscompares++; end
    if (a_grant !== 2'd0)    begin $display("FAIL reset a_grant: got %0d, required 0", a_grant); miscompares++; end
    if (a_busy !== 1'b0)     begin $display("FAIL reset a_busy: got %b, required 0", a_busy); miscompares++; end
    if (b_ascii !== 8'h00)   begin $display("FAIL reset b_ascii: got %h, required 00", b_ascii); miscompares++; end
    if (b_ascii_val !== 1'b0) begin $display("FAIL reset b_ascii_val: got %b, required 0", b_ascii_val); miscompares++; end
    if (b_req_rdy !== 4'h0)  begin $display("FAIL reset b_req_rdy: got %h, required 0", b_req_rdy); miscompares++; end
    if (b_grant !== 2'd0)    begin $display("FAIL reset b_grant: got %0d, required 0", b_grant); miscompares++; end
    if (b_busy !== 1'b0)     begin $display("FAIL reset b_busy: got %b, required 0", b_busy); miscompares++; end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_basic_line();
    bit busy_t[8] = '{0, 1, 1, 1, 1, 1, 0, 0};
    bit rdy_t[8]  = '{0, 0, 0, 1, 1, 1, 0, 0};
    bit val_t[8]  = '{0, 0, 1, 1, 1, 1, 1, 0};
    push_a("0:AB\n");
    fork
      drive_line(1'b0, 0, "AB\n");
      begin
        for (int k = 0; k < 8; k++) begin
          @(negedge clk);
          vectors += 3;
          if (a_busy !== busy_t[k]) begin
            $display("FAIL basic busy cyc%0d: got %b, required %b", k, a_busy, busy_t[k]); miscompares++;
          end
          if (a_req_rdy !== {3'b000, rdy_t[k]}) begin
            $display("FAIL basic req_rdy cyc%0d: got %h, required %h", k, a_req_rdy, {3'b000, rdy_t[k]}); miscompares++;
          end
          if (a_ascii_val !== val_t[k]) begin
            $display("FAIL basic ascii_val cyc%0d: got %b, required %b", k, a_ascii_val, val_t[k]); miscompares++;
          end
        end
      end
    join
    wait_drain("basic");
  endtask

  task automatic test_round_robin();
    push_a("1:x\n2:x\n1:x\n2:x\n");
    fork
      begin drive_line(1'b0, 1, "x\n"); drive_line(1'b0, 1, "x\n"); end
      begin drive_line(1'b0, 2, "x\n"); drive_line(1'b0, 2, "x\n"); end
    join
    wait_drain("round_robin");
    vectors++;
    if (a_grant !== 2'd2) begin
      $display("FAIL round_robin last grant: got %0d, required 2", a_grant); miscompares++;
    end
  endtask

  task automatic test_timeout();
    bit val_t[6] = '{1, 0, 0, 0, 0, 1};
    push_a("3:Q\n");
    drive_line(1'b0, 3, "Q");
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      vectors++;
      if (a_ascii_val !== val_t[k]) begin
        $display("FAIL timeout ascii_val cyc%0d: got %b, required %b", k + 1, a_ascii_val, val_t[k]); miscompares++;
      end
    end
    vectors += 2;
    if (a_grant !== 2'd3) begin $display("FAIL timeout grant: got %0d, required 3", a_grant); miscompares++; end
    if (a_busy !== 1'b0)  begin $display("FAIL timeout busy: got %b, required 0", a_busy); miscompares++; end
    wait_drain("timeout");
  endtask

  task automatic test_esc();
    push_a("0:Z\033");
    push_a("1:m\n");
    fork
      drive_line(1'b0, 0, "Z\033");
      drive_line(1'b0, 1, "m\n");
    join
    wait_drain("esc");
    vectors += 2;
    if (last_seen[8'h31] - last_seen[8'h1B] !== 2) begin
      $display("FAIL esc prefix latency: got %0d, required 2", last_seen[8'h31] - last_seen[8'h1B]); miscompares++;
    end
    if (a_grant !== 2'd1) begin $display("FAIL esc grant: got %0d, required 1", a_grant); miscompares++; end
  endtask

  task automatic test_no_prefix();
    bit val_t[6] = '{0, 0, 1, 1, 1, 0};
    push_b("\177k\n");
    fork
      drive_line(1'b1, 2, "\177k\n");
      begin
        for (int k = 0; k < 6; k++) begin
          @(negedge clk);
          vectors++;
          if (b_ascii_val !== val_t[k]) begin
            $display("FAIL no_prefix ascii_val cyc%0d: got %b, required %b", k, b_ascii_val, val_t[k]); miscompares++;
          end
        end
      end
    join
    wait_drain("no_prefix");
  endtask

  task automatic test_reset_mid_line();
    int n;
    logic take;
    push_a("1:a");
    a_req_ascii[15:8] = "a";
    a_req_val[1] = 1'b1;
    n = 0;
    take = 1'b0;
    while (!take && n < 20) begin
      @(negedge clk);
      take = a_req_rdy[1];
      @(posedge clk);
      #1;
      n++;
    end
    vectors++;
    if (!take) begin $display("FAIL mid_reset accept: got no transfer, required 'a' accepted"); miscompares++; end
    a_req_ascii[15:8] = "b";
    a_req_ascii[7:0]  = "r";
    a_req_val[0] = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    vectors += 4;
    if (a_ascii_val !== 1'b0) begin $display("FAIL mid_reset ascii_val: got %b, required 0", a_ascii_val); miscompares++; end
    if (a_req_rdy !== 4'h0)  begin $display("FAIL mid_reset req_rdy: got %h, required 0", a_req_rdy); miscompares++; end
    if (a_ascii !== 8'h00)   begin $display("FAIL mid_reset ascii: got %h, required 00", a_ascii); miscompares++; end
    if (a_busy !== 1'b0)     begin $display("FAIL mid_reset busy: got %b, required 0", a_busy); miscompares++; end
    @(posedge clk);
    #1;
    rst = 1'b0;
    push_a("0:r\n1:b\n");
    fork
      drive_line(1'b0, 0, "r\n");
      drive_line(1'b0, 1, "b\n");
      begin
        @(negedge clk);
        @(negedge clk);
        vectors += 2;
        if (a_busy !== 1'b1)  begin $display("FAIL mid_reset regrant busy: got %b, required 1", a_busy); miscompares++; end
        if (a_grant !== 2'd0) begin $display("FAIL mid_reset regrant: got %0d, required 0", a_grant); miscompares++; end
      end
    join
    wait_drain("mid_reset");
  endtask

  initial begin
    foreach (last_seen[i]) last_seen[i] = 0;
    rst = 1'b1;
    a_req_ascii = '0; a_req_val = '0;
    b_req_ascii = '0; b_req_val = '0;
    fork
      monitor_loop();
    join_none
    test_reset();
    test_basic_line();
    test_round_robin();
    test_timeout();
    test_esc();
    test_no_prefix();
    test_reset_mid_line();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
